// File: rtl/qupls_rf_write_arbiter.sv
// qupls_rf_write_arbiter
// Collects results from NSRC result buses (valid/ready) and drives up to
// four registered write ports of the physical register file each cycle.
// Grants are handed out in round-robin scan order starting at rr_ptr.
// Results addressed to preg 0 are accepted and dropped without using a port.
//
// WID/RBIT defaults stand in for $bits(cpu_types_pkg::value_t) and
// $clog2(PREGS)-1 so the block builds without the CPU type package.
//
// Optional build macro: QUPLS_WARB_STATS_EN adds the stat_grants and
// stat_stalls saturating counters.

module qupls_rf_write_arbiter #(
  parameter int NSRC = 8,
  parameter int WID  = 64,
  parameter int RBIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NSRC-1:0]            src_v,
  output logic [NSRC-1:0]            src_rdy,
  input  logic [NSRC-1:0][RBIT:0]    src_preg,
  input  logic [NSRC-1:0][WID-1:0]   src_val,
  input  logic [NSRC-1:0]            src_tv,
  input  logic [NSRC-1:0]            src_ti,
  output logic [3:0]                 wr,
  output logic [3:0]                 we,
  output logic [3:0][RBIT:0]         wa,
  output logic [3:0][WID-1:0]        wd,
  output logic [3:0]                 wt,
  output logic [3:0]                 ti,
  output logic                       err_dup
`ifdef QUPLS_WARB_STATS_EN
  ,
  output logic [31:0]                stat_grants,
  output logic [31:0]                stat_stalls
`endif
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        rr_next;

  logic [NSRC-1:0]      rdy_c;
  logic [3:0]           pv_c;
  logic [3:0][PW-1:0]   psel_c;
  logic [2:0]           ngrant_c;
  logic [PW-1:0]        last_c;
  logic [PW:0]          scan_idx;

  logic [3:0][RBIT:0]   nwa;
  logic [3:0][WID-1:0]  nwd;
  logic [3:0]           nwt;
  logic [3:0]           nti;
  logic                 dup_c;

  // Round-robin scan: first four nonzero-preg requesters from rr_ptr get ports
  // 0..3 in order; preg-0 requesters are always accepted and dropped.
  always_comb begin
    rdy_c    = '0;
    pv_c     = '0;
    psel_c   = '0;
    ngrant_c = '0;
    last_c   = rr_ptr;
    scan_idx = '0;
    for (int i = 0; i < NSRC; i++) begin
      scan_idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (scan_idx >= (PW+1)'(NSRC))
        scan_idx = scan_idx - (PW+1)'(NSRC);
      if (src_v[scan_idx[PW-1:0]]) begin
        if (src_preg[scan_idx[PW-1:0]] == '0) begin
          rdy_c[scan_idx[PW-1:0]] = 1'b1;
        end else if (ngrant_c < 3'd4) begin
          rdy_c[scan_idx[PW-1:0]]  = 1'b1;
          pv_c[ngrant_c[1:0]]      = 1'b1;
          psel_c[ngrant_c[1:0]]    = scan_idx[PW-1:0];
          last_c                   = scan_idx[PW-1:0];
          ngrant_c                 = ngrant_c + 3'd1;
        end
      end
    end
  end

  // Ready is held low throughout reset so nothing is consumed while clearing.
  always_comb begin
    src_rdy = rst ? '0 : rdy_c;
  end

  // Steer each granted source onto its port; idle ports carry all zeros.
  always_comb begin
    nwa = '0;
    nwd = '0;
    nwt = '0;
    nti = '0;
    for (int p = 0; p < 4; p++) begin
      if (pv_c[p]) begin
        nwa[p] = src_preg[psel_c[p]];
        nwd[p] = src_val[psel_c[p]];
        nwt[p] = src_tv[psel_c[p]];
        nti[p] = src_ti[psel_c[p]];
      end
    end
  end

  // Flag when two granted ports target the same register (all grants are nonzero).
  always_comb begin
    dup_c = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int q = p + 1; q < 4; q++) begin
        if (pv_c[p] && pv_c[q] && (nwa[p] == nwa[q]))
          dup_c = 1'b1;
      end
    end
  end

  // Pointer moves to just past the last granted source, wrapping at NSRC.
  always_comb begin
    if (last_c == PW'(NSRC - 1))
      rr_next = '0;
    else
      rr_next = last_c + PW'(1);
  end

  // Registered write ports and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr      <= '0;
      we      <= '0;
      wa      <= '0;
      wd      <= '0;
      wt      <= '0;
      ti      <= '0;
      err_dup <= 1'b0;
      rr_ptr  <= '0;
    end else begin
      wr      <= pv_c;
      we      <= pv_c;
      wa      <= nwa;
      wd      <= nwd;
      wt      <= nwt;
      ti      <= nti;
      err_dup <= dup_c;
      if (ngrant_c != 3'd0)
        rr_ptr <= rr_next;
    end
  end

`ifdef QUPLS_WARB_STATS_EN
  logic [32:0] grant_sum;
  logic        stall_c;

  // Any valid source left waiting this cycle counts as a stall cycle.
  always_comb begin
    grant_sum = {1'b0, stat_grants} + 33'(ngrant_c);
    stall_c   = |(src_v & ~rdy_c);
  end

  // Saturating grant and stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      stat_grants <= grant_sum[32] ? '1 : grant_sum[31:0];
      if (stall_c && (stat_stalls != '1))
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qupls_rf_write_arbiter.sv
// Self-checking bench for qupls_rf_write_arbiter: directed scenarios followed
// by randomized traffic compared against a list-based reference model.

module tb_qupls_rf_write_arbiter;

  localparam int NSRC = 8;
  localparam int WID  = 64;
  localparam int RBIT = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NSRC-1:0]           src_v;
  logic [NSRC-1:0]           src_rdy;
  logic [NSRC-1:0][RBIT:0]   src_preg;
  logic [NSRC-1:0][WID-1:0]  src_val;
  logic [NSRC-1:0]           src_tv;
  logic [NSRC-1:0]           src_ti;
  logic [3:0]                wr, we, wt, ti;
  logic [3:0][RBIT:0]        wa;
  logic [3:0][WID-1:0]       wd;
  logic                      err_dup;
`ifdef QUPLS_WARB_STATS_EN
  logic [31:0]               stat_grants, stat_stalls;
`endif

  int total = 0;
  int bad   = 0;

  int              m_rr = 0;
  logic [NSRC-1:0] last_rdy;
  logic [NSRC-1:0] seen_rdy;
  longint          m_grants = 0;
  longint          m_stalls = 0;

  always #5 clk = ~clk;

  qupls_rf_write_arbiter #(.NSRC(NSRC), .WID(WID), .RBIT(RBIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .src_v    (src_v),
    .src_rdy  (src_rdy),
    .src_preg (src_preg),
    .src_val  (src_val),
    .src_tv   (src_tv),
    .src_ti   (src_ti),
    .wr       (wr),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .wt       (wt),
    .ti       (ti),
    .err_dup  (err_dup)
`ifdef QUPLS_WARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int k, input logic [RBIT:0] p, input logic [WID-1:0] v,
                         input logic t, input logic i);
    src_v[k]    = 1'b1;
    src_preg[k] = p;
    src_val[k]  = v;
    src_tv[k]   = t;
    src_ti[k]   = i;
  endtask

  // One clock: reference model picks the winners from a rotated source list,
  // checks ready before the edge and the write ports after it.
  task automatic step();
    logic [NSRC-1:0]     er;
    int                  g[$];
    logic [3:0]          ewr, ewt, eti;
    logic [3:0][RBIT:0]  ewa;
    logic [3:0][WID-1:0] ewd;
    logic                edup;
    logic                stall;
    int                  k;
    #1;
    er = '0;
    stall = 1'b0;
    if (!rst) begin
      for (int j = 0; j < NSRC; j++) begin
        k = (m_rr + j) % NSRC;
        if (src_v[k]) begin
          if (src_preg[k] == 0) er[k] = 1'b1;
          else if (g.size() < 4) begin
            g.push_back(k);
            er[k] = 1'b1;
          end
        end
      end
      for (int j = 0; j < NSRC; j++)
        if (src_v[j] && !er[j]) stall = 1'b1;
    end
    seen_rdy = src_rdy;
    chk("src_rdy", 64'(src_rdy), 64'(er));
    last_rdy = er;

    ewr = '0; ewt = '0; eti = '0; ewa = '0; ewd = '0; edup = 1'b0;
    for (int p = 0; p < g.size(); p++) begin
      ewr[p] = 1'b1;
      ewa[p] = src_preg[g[p]];
      ewd[p] = src_val[g[p]];
      ewt[p] = src_tv[g[p]];
      eti[p] = src_ti[g[p]];
      for (int q = 0; q < p; q++)
        if (src_preg[g[q]] == src_preg[g[p]]) edup = 1'b1;
    end

    @(posedge clk);
    #1;
    if (rst) begin
      m_rr = 0;
      m_grants = 0;
      m_stalls = 0;
      ewr = '0; ewt = '0; eti = '0; ewa = '0; ewd = '0; edup = 1'b0;
    end else begin
      if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % NSRC;
      m_grants = m_grants + g.size();
      if (m_grants > 64'hFFFF_FFFF) m_grants = 64'hFFFF_FFFF;
      if (stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    end
    chk("wr", 64'(wr), 64'(ewr));
    chk("we", 64'(we), 64'(ewr));
    chk("wt", 64'(wt), 64'(ewt));
    chk("ti", 64'(ti), 64'(eti));
    chk("wa", 64'(wa), 64'(ewa));
    for (int p = 0; p < 4; p++) chk("wd", 64'(wd[p]), 64'(ewd[p]));
    chk("err_dup", 64'(err_dup), 64'(edup));
`ifdef QUPLS_WARB_STATS_EN
    chk("stat_grants", 64'(stat_grants), 64'(m_grants));
    chk("stat_stalls", 64'(stat_stalls), 64'(m_stalls));
`endif
  endtask

  initial begin
    rst      = 1'b1;
    src_v    = '1;
    src_preg = '0;
    src_val  = '0;
    src_tv   = '0;
    src_ti   = '0;
    last_rdy = '0;
    seen_rdy = '0;
    for (int k = 0; k < NSRC; k++)
      set_src(k, (RBIT+1)'(k + 1), {$urandom, $urandom}, k[0], k[1]);

    // Reset held with every source valid.
    step();
    step();
    chk("rst_wr", 64'(wr), 64'h0);

    // Saturation: 0-3 then 4-7.
    rst = 1'b0;
    step();
    chk("sat0_wa0", 64'(wa[0]), 64'h1);
    chk("sat0_wa3", 64'(wa[3]), 64'h4);
    step();
    chk("sat1_wa0", 64'(wa[0]), 64'h5);
    chk("sat1_wr", 64'(wr), 64'hF);
    src_v = '0;
    step();

    // Single source on port 0.
    set_src(5, 9'h2A, 64'h1234, 1'b1, 1'b1);
    step();
    chk("single_rdy", 64'(seen_rdy), 64'h20);
    chk("single_wr", 64'(wr), 64'h1);
    chk("single_wd", 64'(wd[0]), 64'h1234);
    src_v = '0;

    // Wrap from rr_ptr = 6 across NSRC-1 -> 0.
    set_src(6, 9'h31, 64'h6, 1'b0, 1'b1);
    set_src(7, 9'h32, 64'h7, 1'b1, 1'b0);
    set_src(0, 9'h33, 64'h0, 1'b1, 1'b1);
    set_src(1, 9'h34, 64'h1, 1'b0, 1'b0);
    set_src(2, 9'h35, 64'h2, 1'b1, 1'b0);
    step();
    chk("wrap_rdy", 64'(seen_rdy), 64'hC3);
    chk("wrap_wa0", 64'(wa[0]), 64'h31);
    chk("wrap_wa3", 64'(wa[3]), 64'h34);
    src_v = '0;
    src_v[2] = 1'b1;
    step();
    chk("wrap_next_wa0", 64'(wa[0]), 64'h35);
    src_v = '0;

    // Preg 0 dropped, source 4 takes port 0.
    set_src(3, 9'h0, 64'hDEAD, 1'b1, 1'b1);
    set_src(4, 9'h20, 64'hBEEF, 1'b0, 1'b1);
    step();
    chk("p0_rdy", 64'(seen_rdy), 64'h18);
    chk("p0_wr", 64'(wr), 64'h1);
    chk("p0_wa0", 64'(wa[0]), 64'h20);
    src_v = '0;

    // Duplicate destination.
    set_src(1, 9'h10, 64'hA, 1'b1, 1'b0);
    set_src(2, 9'h10, 64'hB, 1'b1, 1'b1);
    step();
    chk("dup_flag", 64'(err_dup), 64'h1);
    chk("dup_wr", 64'(wr), 64'h3);
    src_v = '0;
    step();
    chk("dup_clear", 64'(err_dup), 64'h0);

    // Randomized traffic with sources holding until accepted.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < NSRC; k++) begin
        if (!src_v[k] || last_rdy[k]) begin
          if ($urandom_range(0, 9) < 6) begin
            set_src(k, ($urandom_range(0, 7) == 0) ? 9'h0 : (RBIT+1)'($urandom_range(1, 24)),
                    {$urandom, $urandom}, 1'($urandom), 1'($urandom));
          end else begin
            src_v[k] = 1'b0;
          end
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
